riscv_issue: RTL and testbench

RISCV_ISSUE -- requirements
Module: riscv_issue

---
 rtl/riscv_issue.sv | 220 ++++++++++++++++++++++
 tb/tb_riscv_issue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_issue.sv
// Single-entry RV32I decode/issue stage: decodes the fetch word into a one-hot
// vector, holds it in an issue register and supplies operands from a bypassed register file.
module riscv_issue #(
  parameter int unsigned SUPPORT_MUL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_instr_i,
  input  logic [31:0] fetch_pc_i,
  output logic        fetch_accept_o,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  output logic        fetch_branch_o,
  output logic [31:0] fetch_branch_pc_o,
  input  logic [4:0]  writeback_idx_i,
  input  logic        writeback_squash_i,
  input  logic [31:0] writeback_value_i,
  input  logic        stall_i,
  output logic        opcode_valid_o,
  output logic [57:0] opcode_instr_o,
  output logic [31:0] opcode_opcode_o,
  output logic [31:0] opcode_pc_o,
  output logic [4:0]  opcode_rd_idx_o,
  output logic [4:0]  opcode_ra_idx_o,
  output logic [4:0]  opcode_rb_idx_o,
  output logic [31:0] opcode_ra_operand_o,
  output logic [31:0] opcode_rb_operand_o,
  output logic        fault_illegal_o
);

  localparam int unsigned I_ANDI  = 0;
  localparam int unsigned I_ADDI  = 1;
  localparam int unsigned I_SLTI  = 2;
  localparam int unsigned I_SLTIU = 3;
  localparam int unsigned I_ORI   = 4;
  localparam int unsigned I_XORI  = 5;
  localparam int unsigned I_SLLI  = 6;
  localparam int unsigned I_SRLI  = 7;
  localparam int unsigned I_SRAI  = 8;
  localparam int unsigned I_LUI   = 9;
  localparam int unsigned I_AUIPC = 10;
  localparam int unsigned I_ADD   = 11;
  localparam int unsigned I_SUB   = 12;
  localparam int unsigned I_SLT   = 13;
  localparam int unsigned I_SLTU  = 14;
  localparam int unsigned I_XOR   = 15;
  localparam int unsigned I_OR    = 16;
  localparam int unsigned I_AND   = 17;
  localparam int unsigned I_SLL   = 18;
  localparam int unsigned I_SRL   = 19;
  localparam int unsigned I_SRA   = 20;
  localparam int unsigned I_JAL   = 21;
  localparam int unsigned I_JALR  = 22;
  localparam int unsigned I_BEQ   = 23;
  localparam int unsigned I_BNE   = 24;
  localparam int unsigned I_BLT   = 25;
  localparam int unsigned I_BGE   = 26;
  localparam int unsigned I_BLTU  = 27;
  localparam int unsigned I_BGEU  = 28;
  localparam int unsigned I_MUL   = 47;

  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  logic [6:0]  opc_w;
  logic [2:0]  f3_w;
  logic [6:0]  f7_w;
  logic [57:0] dec_w;

  assign opc_w = fetch_instr_i[6:0];
  assign f3_w  = fetch_instr_i[14:12];
  assign f7_w  = fetch_instr_i[31:25];

  always_comb begin
    dec_w = '0;
    case (opc_w)
      OPC_IMM: begin
        case (f3_w)
          3'b000: dec_w[I_ADDI]  = 1'b1;
          3'b010: dec_w[I_SLTI]  = 1'b1;
          3'b011: dec_w[I_SLTIU] = 1'b1;
          3'b100: dec_w[I_XORI]  = 1'b1;
          3'b110: dec_w[I_ORI]   = 1'b1;
          3'b111: dec_w[I_ANDI]  = 1'b1;
          3'b001: dec_w[I_SLLI]  = (f7_w == F7_ZERO);
          3'b101: begin
            dec_w[I_SRLI] = (f7_w == F7_ZERO);
            dec_w[I_SRAI] = (f7_w == F7_ALT);
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        if (f7_w == F7_ZERO) begin
          case (f3_w)
            3'b000:  dec_w[I_ADD]  = 1'b1;
            3'b001:  dec_w[I_SLL]  = 1'b1;
            3'b010:  dec_w[I_SLT]  = 1'b1;
            3'b011:  dec_w[I_SLTU] = 1'b1;
            3'b100:  dec_w[I_XOR]  = 1'b1;
            3'b101:  dec_w[I_SRL]  = 1'b1;
            3'b110:  dec_w[I_OR]   = 1'b1;
            default: dec_w[I_AND]  = 1'b1;
          endcase
        end else if (f7_w == F7_ALT) begin
          dec_w[I_SUB] = (f3_w == 3'b000);
          dec_w[I_SRA] = (f3_w == 3'b101);
        end else if (f7_w == F7_MULDIV) begin
          dec_w[I_MUL] = (f3_w == 3'b000) && (SUPPORT_MUL != 0);
        end
      end
      OPC_LUI:   dec_w[I_LUI]   = 1'b1;
      OPC_AUIPC: dec_w[I_AUIPC] = 1'b1;
      OPC_JAL:   dec_w[I_JAL]   = 1'b1;
      OPC_JALR:  dec_w[I_JALR]  = (f3_w == 3'b000);
      OPC_BRANCH: begin
        case (f3_w)
          3'b000:  dec_w[I_BEQ]  = 1'b1;
          3'b001:  dec_w[I_BNE]  = 1'b1;
          3'b100:  dec_w[I_BLT]  = 1'b1;
          3'b101:  dec_w[I_BGE]  = 1'b1;
          3'b110:  dec_w[I_BLTU] = 1'b1;
          3'b111:  dec_w[I_BGEU] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign fetch_accept_o    = !stall_i && !branch_request_i;
  assign fetch_branch_o    = branch_request_i;
  assign fetch_branch_pc_o = branch_pc_i;

  logic        valid_q;
  logic [57:0] instr_q;
  logic [31:0] opcode_q;
  logic [31:0] pc_q;
  logic [4:0]  rd_q, ra_q, rb_q;
  logic        fault_q;
  logic        fault_d;

  assign fault_d = fetch_accept_o && fetch_valid_i && (dec_w == '0);

  // A redirect only kills the valid bit; the remaining fields are don't-care once invalid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opcode_q <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      fault_q <= fault_d;
      if (branch_request_i) begin
        valid_q <= 1'b0;
      end else if (!stall_i) begin
        valid_q  <= fetch_valid_i;
        instr_q  <= dec_w;
        opcode_q <= fetch_instr_i;
        pc_q     <= fetch_pc_i;
        rd_q     <= fetch_instr_i[11:7];
        ra_q     <= fetch_instr_i[19:15];
        rb_q     <= fetch_instr_i[24:20];
      end
    end
  end

  logic [31:0] regs_q [31:1];
  logic        wb_en_w;

  assign wb_en_w = (writeback_idx_i != 5'd0) && !writeback_squash_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 1; i < 32; i++) regs_q[i[4:0]] <= '0;
    end else if (wb_en_w) begin
      regs_q[writeback_idx_i] <= writeback_value_i;
    end
  end

  // Bypass the in-flight writeback so a dependent instruction issues back-to-back.
  always_comb begin
    opcode_ra_operand_o = '0;
    if (ra_q != 5'd0) begin
      if (wb_en_w && (ra_q == writeback_idx_i)) opcode_ra_operand_o = writeback_value_i;
      else                                      opcode_ra_operand_o = regs_q[ra_q];
    end
  end

  always_comb begin
    opcode_rb_operand_o = '0;
    if (rb_q != 5'd0) begin
      if (wb_en_w && (rb_q == writeback_idx_i)) opcode_rb_operand_o = writeback_value_i;
      else                                      opcode_rb_operand_o = regs_q[rb_q];
    end
  end

  assign opcode_valid_o  = valid_q;
  assign opcode_instr_o  = instr_q;
  assign opcode_opcode_o = opcode_q;
  assign opcode_pc_o     = pc_q;
  assign opcode_rd_idx_o = rd_q;
  assign opcode_ra_idx_o = ra_q;
  assign opcode_rb_idx_o = rb_q;
  assign fault_illegal_o = fault_q;

endmodule

// File: tb/tb_riscv_issue.sv
// Directed bench for riscv_issue: decode table plus reset, forwarding,
// branch squash, stall and illegal-word sequences.
module tb_riscv_issue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_instr_i, fetch_pc_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic [4:0]  writeback_idx_i;
  logic        writeback_squash_i;
  logic [31:0] writeback_value_i;
  logic        stall_i;

  logic        fetch_accept_o, fetch_branch_o, opcode_valid_o, fault_illegal_o;
  logic [31:0] fetch_branch_pc_o, opcode_opcode_o, opcode_pc_o;
  logic [57:0] opcode_instr_o;
  logic [4:0]  opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o;
  logic [31:0] opcode_ra_operand_o, opcode_rb_operand_o;

  logic        n_accept, n_branch, n_valid, n_fault;
  logic [31:0] n_branch_pc, n_opcode, n_pc, n_ra_op, n_rb_op;
  logic [57:0] n_instr;
  logic [4:0]  n_rd, n_ra, n_rb;

  always #5 clk = ~clk;

  riscv_issue #(.SUPPORT_MUL(1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
    .fetch_accept_o(fetch_accept_o),
    .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
    .fetch_branch_o(fetch_branch_o), .fetch_branch_pc_o(fetch_branch_pc_o),
    .writeback_idx_i(writeback_idx_i), .writeback_squash_i(writeback_squash_i),
    .writeback_value_i(writeback_value_i), .stall_i(stall_i),
    .opcode_valid_o(opcode_valid_o), .opcode_instr_o(opcode_instr_o),
    .opcode_opcode_o(opcode_opcode_o), .opcode_pc_o(opcode_pc_o),
    .opcode_rd_idx_o(opcode_rd_idx_o), .opcode_ra_idx_o(opcode_ra_idx_o),
    .opcode_rb_idx_o(opcode_rb_idx_o),
    .opcode_ra_operand_o(opcode_ra_operand_o), .opcode_rb_operand_o(opcode_rb_operand_o),
    .fault_illegal_o(fault_illegal_o)
  );

  riscv_issue #(.SUPPORT_MUL(0)) u_nomul (
    .clk_i(clk), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
    .fetch_accept_o(n_accept),
    .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
    .fetch_branch_o(n_branch), .fetch_branch_pc_o(n_branch_pc),
    .writeback_idx_i(writeback_idx_i), .writeback_squash_i(writeback_squash_i),
    .writeback_value_i(writeback_value_i), .stall_i(stall_i),
    .opcode_valid_o(n_valid), .opcode_instr_o(n_instr),
    .opcode_opcode_o(n_opcode), .opcode_pc_o(n_pc),
    .opcode_rd_idx_o(n_rd), .opcode_ra_idx_o(n_ra), .opcode_rb_idx_o(n_rb),
    .opcode_ra_operand_o(n_ra_op), .opcode_rb_operand_o(n_rb_op),
    .fault_illegal_o(n_fault)
  );

  typedef struct {
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stall;
    logic        br;
    int          exp_bit;
    logic        exp_valid;
    logic [31:0] exp_op;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t        tbl[$];
  vec_t        last;
  logic [31:0] next_pc = 32'h1000;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int b);
    return (b < 0) ? 64'd0 : (64'd1 << b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid_i = v;
    fetch_instr_i = ins;
    fetch_pc_i    = pc;
  endtask

  task automatic dec_row(input logic [31:0] ins, input int b);
    vec_t r;
    r.fv = 1'b1; r.instr = ins; r.pc = next_pc; r.stall = 1'b0; r.br = 1'b0;
    r.exp_bit = b; r.exp_valid = 1'b1; r.exp_op = ins; r.exp_pc = next_pc;
    r.exp_fault = (b < 0);
    next_pc += 32'd4;
    tbl.push_back(r);
    last = r;
  endtask

  task automatic hold_row(input logic st, input logic br);
    vec_t r;
    r = last;
    r.fv = 1'b1; r.instr = 32'h00510093; r.pc = 32'hBAD0; r.stall = st; r.br = br;
    r.exp_fault = 1'b0;
    if (br) r.exp_valid = 1'b0;
    tbl.push_back(r);
    last = r;
  endtask

  initial begin
    rst_i = 1'b0;
    fetch(1'b1, 32'h00510093, 32'h80);
    branch_request_i = 1'b0; branch_pc_i = '0; stall_i = 1'b0;
    writeback_idx_i = '0; writeback_squash_i = 1'b0; writeback_value_i = '0;

    // Reset with a valid fetch pending
    #12;
    chk("rst_valid", 64'(opcode_valid_o), 64'd0);
    chk("rst_instr", 64'(opcode_instr_o), 64'd0);
    chk("rst_pc",    64'(opcode_pc_o),    64'd0);
    chk("rst_fault", 64'(fault_illegal_o), 64'd0);
    chk("rst_ops",   {opcode_ra_operand_o, opcode_rb_operand_o}, 64'd0);
    #1 rst_i = 1'b1;
    tick();
    chk("rel_valid", 64'(opcode_valid_o), 64'd1);
    chk("rel_pc",    64'(opcode_pc_o),    64'h80);
    chk("rel_instr", 64'(opcode_instr_o), onehot(1));

    for (int r = 1; r < 32; r++) begin
      fetch(1'b1, (32'(r) << 20) | (32'(r) << 15) | 32'h33, 32'h90);
      tick();
      chk($sformatf("rst_x%0d", r), {opcode_ra_operand_o, opcode_rb_operand_o}, 64'd0);
    end

    // Forwarding: addi x1,x0,5 ; add x2,x1,x1 ; add x3,x2,x1
    fetch(1'b1, 32'h00500093, 32'hA0);
    tick();
    chk("fw_addi_instr", 64'(opcode_instr_o), onehot(1));
    chk("fw_addi_rd",    64'(opcode_rd_idx_o), 64'd1);
    fetch(1'b1, 32'h00108133, 32'hA4);
    tick();
    writeback_idx_i = 5'd1; writeback_value_i = 32'd5;
    fetch(1'b1, 32'h001101B3, 32'hA8);
    #1;
    chk("fw_add_valid", 64'(opcode_valid_o), 64'd1);
    chk("fw_add_ra", 64'(opcode_ra_operand_o), 64'd5);
    chk("fw_add_rb", 64'(opcode_rb_operand_o), 64'd5);
    tick();
    writeback_idx_i = 5'd2; writeback_value_i = 32'd10;
    fetch(1'b0, 32'h001101B3, 32'hAC);
    #1;
    chk("fw_x2_bypass", 64'(opcode_ra_operand_o), 64'd10);
    chk("fw_x1_file",   64'(opcode_rb_operand_o), 64'd5);
    tick();
    writeback_idx_i = '0; writeback_value_i = '0;
    #1;
    chk("fw_x2_file", 64'(opcode_ra_operand_o), 64'd10);
    chk("fw_nv",      64'(opcode_valid_o), 64'd0);

    // Branch squash
    fetch(1'b1, 32'h00000463, 32'h100);
    tick();
    chk("br_beq_instr", 64'(opcode_instr_o), onehot(23));
    chk("br_beq_pc",    64'(opcode_pc_o), 64'h100);
    branch_request_i = 1'b1; branch_pc_i = 32'h108;
    fetch(1'b1, 32'h00510093, 32'h104);
    #1;
    chk("br_req", 64'(fetch_branch_o), 64'd1);
    chk("br_pc",  64'(fetch_branch_pc_o), 64'h108);
    chk("br_acc", 64'(fetch_accept_o), 64'd0);
    tick();
    chk("br_squash", 64'(opcode_valid_o), 64'd0);
    branch_request_i = 1'b0;
    fetch(1'b1, 32'h003100B3, 32'h108);
    #1;
    chk("br_req_off", 64'(fetch_branch_o), 64'd0);
    tick();
    chk("br_tgt_valid", 64'(opcode_valid_o), 64'd1);
    chk("br_tgt_pc",    64'(opcode_pc_o), 64'h108);

    // Stall for three cycles
    fetch(1'b1, 32'h00510093, 32'h200);
    tick();
    stall_i = 1'b1;
    fetch(1'b1, 32'h003100B3, 32'h204);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st_acc%0d", k), 64'(fetch_accept_o), 64'd0);
      tick();
      chk($sformatf("st_hold%0d", k), {opcode_pc_o, opcode_opcode_o}, {32'h200, 32'h00510093});
      chk($sformatf("st_vld%0d", k), 64'(opcode_valid_o), 64'd1);
    end
    stall_i = 1'b0;
    #1;
    chk("st_acc_resume", 64'(fetch_accept_o), 64'd1);
    tick();
    chk("st_resume", {opcode_pc_o, opcode_opcode_o}, {32'h204, 32'h003100B3});

    // Reset while stalled discards the held word and clears the register file
    stall_i = 1'b1;
    fetch(1'b1, 32'h00510093, 32'h208);
    tick();
    #2 rst_i = 1'b0;
    #1;
    chk("mrst_valid", 64'(opcode_valid_o), 64'd0);
    chk("mrst_pc",    64'(opcode_pc_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b1; stall_i = 1'b0;
    fetch(1'b1, 32'h00208033, 32'h300);
    tick();
    chk("mrst_first", {32'(opcode_valid_o), opcode_pc_o}, {32'd1, 32'h300});
    chk("mrst_regs",  {opcode_ra_operand_o, opcode_rb_operand_o}, 64'd0);

    // Illegal word pulse, then squashed writeback to x3
    fetch(1'b1, 32'hFFFFFFFF, 32'h400);
    tick();
    chk("ill_instr", 64'(opcode_instr_o), 64'd0);
    chk("ill_fault", 64'(fault_illegal_o), 64'd1);
    chk("ill_valid", 64'(opcode_valid_o), 64'd1);
    fetch(1'b0, 32'h00318033, 32'h404);
    tick();
    chk("ill_fault_off", 64'(fault_illegal_o), 64'd0);
    fetch(1'b1, 32'h00318033, 32'h408);
    tick();
    writeback_idx_i = 5'd3; writeback_squash_i = 1'b1; writeback_value_i = 32'hDEADBEEF;
    #1;
    chk("sq_nobypass", {opcode_ra_operand_o, opcode_rb_operand_o}, 64'd0);
    tick();
    writeback_idx_i = '0; writeback_squash_i = 1'b0; writeback_value_i = '0;
    #1;
    chk("sq_x3", 64'(opcode_ra_operand_o), 64'd0);

    // Decode and hold table
    dec_row(32'h003100B3, 11); dec_row(32'h403100B3, 12); dec_row(32'h003110B3, 18);
    dec_row(32'h003120B3, 13); dec_row(32'h003130B3, 14); dec_row(32'h003140B3, 15);
    dec_row(32'h003150B3, 19); dec_row(32'h403150B3, 20); dec_row(32'h003160B3, 16);
    dec_row(32'h003170B3, 17); dec_row(32'h023100B3, 47); dec_row(32'h403110B3, -1);
    dec_row(32'h00510093, 1);  dec_row(32'h00512093, 2);  dec_row(32'h00513093, 3);
    dec_row(32'h00514093, 5);  dec_row(32'h00516093, 4);  dec_row(32'h00517093, 0);
    dec_row(32'h00511093, 6);  dec_row(32'h00515093, 7);  dec_row(32'h40515093, 8);
    dec_row(32'h20515093, -1); dec_row(32'h123450B7, 9);  dec_row(32'h12345097, 10);
    dec_row(32'h008000EF, 21); dec_row(32'h000100E7, 22); dec_row(32'h000110E7, -1);
    dec_row(32'h00310463, 23); dec_row(32'h00311463, 24); dec_row(32'h00314463, 25);
    dec_row(32'h00315463, 26); dec_row(32'h00316463, 27); dec_row(32'h00317463, 28);
    dec_row(32'h00312463, -1); dec_row(32'h00012083, -1);
    hold_row(1'b1, 1'b0);
    dec_row(32'h00000000, -1);
    dec_row(32'h003100B3, 11);
    hold_row(1'b1, 1'b0);
    hold_row(1'b1, 1'b1);
    hold_row(1'b0, 1'b1);
    begin
      vec_t r;
      r.fv = 1'b0; r.instr = 32'hFFFFFFFF; r.pc = 32'h2000; r.stall = 1'b0; r.br = 1'b0;
      r.exp_bit = -1; r.exp_valid = 1'b0; r.exp_op = 32'hFFFFFFFF; r.exp_pc = 32'h2000;
      r.exp_fault = 1'b0;
      tbl.push_back(r);
    end

    foreach (tbl[i]) begin
      vec_t r;
      logic [63:0] v2;
      logic        f2;
      r = tbl[i];
      fetch(r.fv, r.instr, r.pc);
      stall_i = r.stall; branch_request_i = r.br; branch_pc_i = 32'h5000;
      #1;
      chk($sformatf("t%0d_accept", i), 64'(fetch_accept_o), 64'(!r.stall && !r.br));
      tick();
      chk($sformatf("t%0d_instr", i), 64'(opcode_instr_o), onehot(r.exp_bit));
      chk($sformatf("t%0d_valid", i), 64'(opcode_valid_o), 64'(r.exp_valid));
      chk($sformatf("t%0d_fault", i), 64'(fault_illegal_o), 64'(r.exp_fault));
      chk($sformatf("t%0d_oppc", i), {opcode_opcode_o, opcode_pc_o}, {r.exp_op, r.exp_pc});
      chk($sformatf("t%0d_idx", i),
          64'({opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o}),
          64'({r.exp_op[11:7], r.exp_op[19:15], r.exp_op[24:20]}));
      v2 = (r.exp_bit == 47) ? 64'd0 : onehot(r.exp_bit);
      f2 = r.exp_fault || (r.exp_bit == 47 && r.fv && !r.stall && !r.br);
      chk($sformatf("t%0d_nomul", i), {5'd0, f2, v2[57:0]}, {5'd0, n_fault, n_instr});
    end
    stall_i = 1'b0; branch_request_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
